// File: rtl/psum_acc_if.sv
// psum_acc_if: upstream beat channel and downstream accumulated-beat channel of psum_acc
interface psum_acc_if #(
  parameter int LANES = 32,
  parameter int PSUM_W = 24
);
  logic mac_array2psum_acc_vld;
  logic mac_array2psum_acc_rdy;
  logic [LANES*PSUM_W-1:0] mac_array2psum_acc_data;
  logic [31:0] mac_array2psum_acc_info;
  logic psum_acc_out_vld;
  logic psum_acc_out_rdy;
  logic [LANES*(PSUM_W+1)-1:0] psum_acc_out_data;
  logic [12:0] psum_acc_out_info;
  modport slave (
    input  mac_array2psum_acc_vld, mac_array2psum_acc_data, mac_array2psum_acc_info, psum_acc_out_rdy,
    output mac_array2psum_acc_rdy, psum_acc_out_vld, psum_acc_out_data, psum_acc_out_info
  );
  modport master (
    output mac_array2psum_acc_vld, mac_array2psum_acc_data, mac_array2psum_acc_info, psum_acc_out_rdy,
    input  mac_array2psum_acc_rdy, psum_acc_out_vld, psum_acc_out_data, psum_acc_out_info
  );
endinterface

// File: rtl/psum_acc.sv
// psum_acc: buffers group-0 partial sums per map offset and adds group-1 beats onto them
module psum_acc #(
  parameter int LANES = 32,
  parameter int PSUM_W = 24,
  parameter int MAP_SIZE = 3136
) (
  input  logic      clk,
  input  logic      rst,
  psum_acc_if.slave bus,
  input  logic      err_clr,
  output logic      psum_acc_done,
  output logic      psum_acc_err
);
  localparam int IW = LANES*PSUM_W;
  localparam int OW = LANES*(PSUM_W+1);
  localparam int AW = MAP_SIZE > 1 ? $clog2(MAP_SIZE) : 1;
  localparam logic [11:0] LAST = 12'(MAP_SIZE-1);
  typedef enum logic {FILL, ACC} state_t;
  state_t state, state_nxt;
  logic [11:0] exp_cnt, exp_cnt_nxt, offset;
  logic [IW-1:0] mem [MAP_SIZE];
  logic [IW-1:0] rd_data, s1_data;
  logic [12:0] s1_info;
  logic [AW-1:0] addr;
  logic [OW-1:0] sum;
  logic s1_vld, advance, accept, grp, err_set, unused_info;
  assign offset = bus.mac_array2psum_acc_info[11:0];
  assign grp = bus.mac_array2psum_acc_info[12];
  assign addr = offset[AW-1:0];
  assign unused_info = ^bus.mac_array2psum_acc_info[31:14];
  assign advance = !bus.psum_acc_out_vld || bus.psum_acc_out_rdy;
  assign bus.mac_array2psum_acc_rdy = !s1_vld || advance;
  assign accept = bus.mac_array2psum_acc_vld && bus.mac_array2psum_acc_rdy;
  // a mismatching beat is flagged but still processed according to its own group bit
  assign err_set = accept && ((grp != (state == ACC)) || (offset != exp_cnt));
  always_comb begin
    state_nxt = state;
    exp_cnt_nxt = exp_cnt;
    if (accept) begin
      exp_cnt_nxt = exp_cnt == LAST ? '0 : exp_cnt + 12'd1;
      state_nxt = exp_cnt == LAST ? (state == FILL ? ACC : FILL) : state;
    end
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum[k*(PSUM_W+1) +: PSUM_W+1] = {s1_data[k*PSUM_W+PSUM_W-1], s1_data[k*PSUM_W +: PSUM_W]}
                                    + {rd_data[k*PSUM_W+PSUM_W-1], rd_data[k*PSUM_W +: PSUM_W]};
  end
  // group-1 read and S1 capture share the accept edge so rd_data lines up with s1_data
  always_ff @(posedge clk) begin
    if (accept && !grp) mem[addr] <= bus.mac_array2psum_acc_data;
    if (accept && grp) begin
      rd_data <= mem[addr];
      s1_data <= bus.mac_array2psum_acc_data;
      s1_info <= {bus.mac_array2psum_acc_info[13], offset};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      exp_cnt <= '0;
      s1_vld <= 1'b0;
      bus.psum_acc_out_vld <= 1'b0;
      bus.psum_acc_out_data <= '0;
      bus.psum_acc_out_info <= '0;
      psum_acc_done <= 1'b0;
      psum_acc_err <= 1'b0;
    end else begin
      state <= state_nxt;
      exp_cnt <= exp_cnt_nxt;
      s1_vld <= (accept && grp) || (s1_vld && !advance);
      if (advance) bus.psum_acc_out_vld <= s1_vld;
      if (advance && s1_vld) begin
        bus.psum_acc_out_data <= sum;
        bus.psum_acc_out_info <= s1_info;
      end
      psum_acc_done <= bus.psum_acc_out_vld && bus.psum_acc_out_rdy && bus.psum_acc_out_info[11:0] == LAST;
      psum_acc_err <= err_set || (psum_acc_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: randomized and directed scoreboard bench for psum_acc (MAP_SIZE=4, LANES=2, PSUM_W=8)
module tb_psum_acc;
  localparam int MS = 4;
  logic clk = 0, rst = 1, err_clr = 0, done, err;
  psum_acc_if #(.LANES(2), .PSUM_W(8)) bus ();
  psum_acc #(.LANES(2), .PSUM_W(8), .MAP_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr), .psum_acc_done(done), .psum_acc_err(err)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int n_acc = 0;
  int buf_m [MS][2];
  logic [30:0] q [$];
  logic m_set = 0, m_err = 0, done_exp = 0, done_nxt = 0;
  logic rand_rdy = 0, stall_prev = 0;
  logic [17:0] prev_data;
  logic [12:0] prev_info;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: the accept count alone determines which group and offset are due
  task automatic model_accept(bit g, int off, int l0, int l1, bit h);
    logic [8:0] s0, s1;
    if (g != ((n_acc / MS) % 2 == 1) || off != n_acc % MS) m_set = 1;
    n_acc++;
    if (!g) begin
      buf_m[off][0] = l0;
      buf_m[off][1] = l1;
    end else begin
      s0 = 9'(l0 + buf_m[off][0]);
      s1 = 9'(l1 + buf_m[off][1]);
      q.push_back({h, 12'(off), s1, s0});
    end
  endtask

  task automatic send(bit g, int off, int l0, int l1, bit h = 0, bit clr = 0);
    int n = 0;
    bus.mac_array2psum_acc_vld = 1;
    bus.mac_array2psum_acc_data = {8'(l1), 8'(l0)};
    bus.mac_array2psum_acc_info = {18'($urandom), h, g, 12'(off)};
    @(negedge clk);
    while (!bus.mac_array2psum_acc_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mac_array2psum_acc_rdy) chk("send_timeout", 0, 1);
    else model_accept(g, off, l0, l1, h);
    if (clr) err_clr = 1;
    @(posedge clk);
    #1;
    bus.mac_array2psum_acc_vld = 0;
    err_clr = 0;
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int rl();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.psum_acc_out_rdy = $urandom_range(0, 3) != 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_exp = 0;
      m_err = 0;
      m_set = 0;
    end else begin
      done_exp = done_nxt;
      m_err = m_set ? 1'b1 : (err_clr ? 1'b0 : m_err);
      m_set = 0;
    end
  end

  always @(negedge clk) begin
    logic [30:0] e;
    if (rst) begin
      done_nxt = 0;
      stall_prev = 0;
    end else begin
      chk("done", done, done_exp);
      chk("err", err, m_err);
      if (stall_prev) begin
        chk("hold_vld", bus.psum_acc_out_vld, 1);
        chk("hold_data", bus.psum_acc_out_data, prev_data);
        chk("hold_info", bus.psum_acc_out_info, prev_info);
      end
      done_nxt = 0;
      if (bus.psum_acc_out_vld && bus.psum_acc_out_rdy) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", bus.psum_acc_out_data, e[17:0]);
          chk("out_info", bus.psum_acc_out_info, e[30:18]);
        end
        done_nxt = bus.psum_acc_out_info[11:0] == 12'(MS-1);
      end
      stall_prev = bus.psum_acc_out_vld && !bus.psum_acc_out_rdy;
      prev_data = bus.psum_acc_out_data;
      prev_info = bus.psum_acc_out_info;
    end
  end

  initial begin
    bus.mac_array2psum_acc_vld = 0;
    bus.mac_array2psum_acc_data = '0;
    bus.mac_array2psum_acc_info = '0;
    bus.psum_acc_out_rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", bus.psum_acc_out_vld, 0);
    chk("rst_out_data", bus.psum_acc_out_data, 0);
    chk("rst_out_info", bus.psum_acc_out_info, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst_rdy", bus.mac_array2psum_acc_rdy, 1);
    // basic map: 1+3=4, -2+5=3
    for (int i = 0; i < MS; i++) send(0, i, 1, -2);
    for (int i = 0; i < MS; i++) send(1, i, 3, 5, 1);
    drain();
    // lane overflow into the extra sum bit
    for (int i = 0; i < MS; i++) send(0, i, 127, -128);
    for (int i = 0; i < MS; i++) send(1, i, 127, -128);
    drain();
    // downstream stall for 5 cycles while group-1 beats arrive
    for (int i = 0; i < MS; i++) send(0, i, rl(), rl());
    bus.psum_acc_out_rdy = 0;
    fork
      for (int i = 0; i < MS; i++) send(1, i, rl(), rl());
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("stall_up_rdy", bus.mac_array2psum_acc_rdy, 0);
        chk("stall_out_vld", bus.psum_acc_out_vld, 1);
        bus.psum_acc_out_rdy = 1;
      end
    join
    drain();
    // protocol errors: wrong group, then wrong offset, then clear racing a new error
    send(1, 0, rl(), rl());
    for (int i = 1; i < MS; i++) send(0, i, rl(), rl());
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    pulse_clr();
    send(1, 0, rl(), rl());
    send(1, 2, rl(), rl());
    send(1, 2, rl(), rl());
    send(1, 3, rl(), rl());
    drain();
    pulse_clr();
    send(0, 1, rl(), rl(), 0, 1);
    for (int i = 1; i < MS; i++) send(0, i, rl(), rl());
    for (int i = 0; i < MS; i++) send(1, i, rl(), rl());
    drain();
    chk("err_clr_loses", err, 1);
    pulse_clr();
    // reset in the middle of the accumulate phase
    for (int i = 0; i < MS; i++) send(0, i, rl(), rl());
    send(1, 0, rl(), rl());
    send(1, 1, rl(), rl());
    rst = 1;
    #1;
    chk("midrst_out_vld", bus.psum_acc_out_vld, 0);
    chk("midrst_err", err, 0);
    q.delete();
    n_acc = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < MS; i++) send(0, i, rl(), rl());
    for (int i = 0; i < MS; i++) send(1, i, rl(), rl(), 1);
    drain();
    // random back-to-back maps with random gaps and downstream backpressure
    rand_rdy = 1;
    for (int m = 0; m < 8; m++) begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < MS; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(1'(g), i, rl(), rl(), 1'($urandom));
        end
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    bus.psum_acc_out_rdy = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
